ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single RAM port between the coherence controller's data-side requests and the two instruction caches (icache0, icache1).
- Grants one requester at a time and holds the grant until the RAM reports ACCESS.
- Data side has priority, with a starvation guard for instruction fetch.
- Data side may lock the port across a multi-word block transfer.
- Sits between the coherence controller / icaches and the RAM model.

Parameters:
- WORD_W, 32, width of address and data words.
- STARVE_MAX, 8, consecutive completed data transactions after which a pending instruction request is forced ahead.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- dREN  in  1  data-side read request (from coherence controller).
- dWEN  in  1  data-side write request.
- dlock  in  1  keep the port on the data side after the current ACCESS (block in progress).
- daddr  in  WORD_W  data-side address.
- dstore  in  WORD_W  data-side write data.
- dwait  out  1  low for exactly the ACCESS cycle of a data transaction.
- dload  out  WORD_W  ramload, passed through while data is granted, else 0.
- iREN  in  2  instruction fetch request, one bit per icache.
- iaddr  in  2 x WORD_W  fetch address per icache.
- iwait  out  2  per-icache wait, low only in that icache's ACCESS cycle.
- iload  out  2 x WORD_W  ramload to the granted icache, else 0.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Behaviour:
- Reset (async, any time, including mid-transaction):
  - state=IDLE, rr=0, starve=0.
  - ramREN=ramWEN=0, ramaddr=ramstore=0.
  - dwait=1, iwait=2'b11, dload=iload=0.
  - Any in-flight RAM access is abandoned; requesters re-issue.
- States: IDLE, GNT_D, GNT_I0, GNT_I1. State register is clocked; outputs are combinational from the registered state.
- IDLE: drives no RAM enables and all waits high. Next state is chosen in priority order:
  - 1. If any iREN and starve==STARVE_MAX: GNT_I[rr] if iREN[rr], else the other icache.
  - 2. Else if dREN|dWEN: GNT_D.
  - 3. Else if both iREN: GNT_I[rr].
  - 4. Else if one iREN: that icache.
  - 5. Else stay in IDLE.
- Grant latency: a request sampled in IDLE at edge N drives the RAM from cycle N+1. Minimum transaction is 2 cycles (IDLE + ACCESS cycle).
- GNT_D:
  - ramREN=dREN, ramWEN=dWEN; if both are high, ramWEN wins and ramREN=0.
  - ramaddr=daddr, ramstore=dstore, dload=ramload.
  - dwait=(ramstate!=ACCESS).
  - On ACCESS:
    - starve increments if any iREN is pending (saturating at STARVE_MAX), else clears.
    - Next state: GNT_D if dlock && starve<STARVE_MAX, else IDLE.
  - If the data request drops without ACCESS, return to IDLE with no dwait pulse.
- GNT_Ix:
  - ramREN=1, ramWEN=0, ramaddr=iaddr[x], iload[x]=ramload.
  - iwait[x]=(ramstate!=ACCESS).
  - On ACCESS: rr=~x, starve=0, next state IDLE.
  - If iREN[x] drops before ACCESS, return to IDLE.
- dlock under starvation: lock is honoured until starve reaches STARVE_MAX. It is then broken after the current ACCESS. The coherence controller tolerates this because dwait stays high until re-grant.
- ERROR and BUSY: treated identically. Hold the grant, keep the wait high, keep driving the RAM.
- Waits never fall in IDLE. At most one wait bit is low in any cycle.
- rr changes only on completion of an instruction ACCESS.

Test Plan:
- Reset/idle: assert RST mid-GNT_D with ramstate=BUSY -> next cycle ramREN=ramWEN=0, dwait=1, iwait=11. After release with no requests, outputs stay idle.
- Single data read: dREN=1, daddr=0x100, ACCESS on 3rd RAM cycle with ramload=0xDEADBEEF -> ramREN high from cycle 1. dwait low only in the ACCESS cycle with dload=0xDEADBEEF. Returns to IDLE.
- Priority: dWEN=1 and iREN=11 together -> data granted first, then icache0, then icache1. rr toggles after each icache ACCESS.
- Lock: dlock=1 across two data words at 0x200/0x204 while iREN[0]=1 -> no icache grant between the words. icache granted after dlock drops.
- Starvation: dlock=1 held with iREN[1]=1, STARVE_MAX=8 -> icache1 granted after the 8th data ACCESS despite dlock. starve resets to 0.
- Abort: iREN[0] drops while GNT_I0 and ramstate=BUSY -> ramREN=0 next cycle, no iwait pulse, state IDLE.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle joining the coherence controller, the two icaches and the RAM model
// to the RAM port arbiter.
interface ram_port_arbiter_if #(
    parameter int WORD_W = 32
);
    logic                   dREN;
    logic                   dWEN;
    logic                   dlock;
    logic [WORD_W-1:0]      daddr;
    logic [WORD_W-1:0]      dstore;
    logic                   dwait;
    logic [WORD_W-1:0]      dload;
    logic [1:0]             iREN;
    logic [1:0][WORD_W-1:0] iaddr;
    logic [1:0]             iwait;
    logic [1:0][WORD_W-1:0] iload;
    logic                   ramREN;
    logic                   ramWEN;
    logic [WORD_W-1:0]      ramaddr;
    logic [WORD_W-1:0]      ramstore;
    logic [WORD_W-1:0]      ramload;
    logic [1:0]             ramstate;

    modport slave (
        input  dREN, dWEN, dlock, daddr, dstore, iREN, iaddr, ramload, ramstate,
        output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output dREN, dWEN, dlock, daddr, dstore, iREN, iaddr, ramload, ramstate,
        input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single RAM port between data-side requests and two icaches;
// data has priority, bounded by a starvation guard for instruction fetch.
module ram_port_arbiter #(
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              CLK,
    input  logic              RST,
    ram_port_arbiter_if.slave bus
);
    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_0   = {SW{1'b0}};
    localparam logic [1:0]    RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_D  = 2'd1,
        GNT_I0 = 2'd2,
        GNT_I1 = 2'd3
    } state_t;

    state_t        state_r;
    state_t        next_state_s;
    logic          rr_r;
    logic [SW-1:0] starve_r;
    logic [SW-1:0] starve_next_s;
    logic          access_s;
    logic          d_req_s;
    logic          i_any_s;
    logic          pick_s;

    assign access_s = (bus.ramstate == RAM_ACCESS);
    assign d_req_s  = bus.dREN | bus.dWEN;
    assign i_any_s  = |bus.iREN;
    // rr's icache if it is asking, otherwise the other one (the only one left asking)
    assign pick_s   = bus.iREN[rr_r] ? rr_r : ~rr_r;

    // Starvation count after a data ACCESS: saturating while a fetch waits, else cleared.
    always_comb begin
        starve_next_s = STARVE_0;
        if (i_any_s) begin
            if (starve_r == STARVE_LIM) begin
                starve_next_s = STARVE_LIM;
            end else begin
                starve_next_s = starve_r + SW'(1);
            end
        end else begin
            starve_next_s = STARVE_0;
        end
    end

    // Grant state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Round-robin pointer and starvation counter, updated only on completed accesses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_r     <= 1'b0;
            starve_r <= STARVE_0;
        end else if (access_s) begin
            case (state_r)
                GNT_D: begin
                    starve_r <= starve_next_s;
                end
                GNT_I0: begin
                    rr_r     <= 1'b1;
                    starve_r <= STARVE_0;
                end
                GNT_I1: begin
                    rr_r     <= 1'b0;
                    starve_r <= STARVE_0;
                end
                default: begin
                    starve_r <= starve_r;
                end
            endcase
        end
    end

    // Next grant: starved fetch first, then data, then icaches; grants end on ACCESS or drop.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_any_s && (starve_r == STARVE_LIM)) begin
                    next_state_s = pick_s ? GNT_I1 : GNT_I0;
                end else if (d_req_s) begin
                    next_state_s = GNT_D;
                end else if (i_any_s) begin
                    next_state_s = pick_s ? GNT_I1 : GNT_I0;
                end else begin
                    next_state_s = IDLE;
                end
            end
            GNT_D: begin
                if (access_s) begin
                    next_state_s = (bus.dlock && (starve_next_s < STARVE_LIM)) ? GNT_D : IDLE;
                end else if (!d_req_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = GNT_D;
                end
            end
            GNT_I0: begin
                if (access_s || !bus.iREN[0]) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = GNT_I0;
                end
            end
            GNT_I1: begin
                if (access_s || !bus.iREN[1]) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = GNT_I1;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // RAM drive and requester responses decoded from the registered grant.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = {WORD_W{1'b0}};
        bus.ramstore = {WORD_W{1'b0}};
        bus.dwait    = 1'b1;
        bus.dload    = {WORD_W{1'b0}};
        bus.iwait    = 2'b11;
        bus.iload    = {(2 * WORD_W){1'b0}};
        case (state_r)
            GNT_D: begin
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.dload    = bus.ramload;
                bus.dwait    = ~access_s;
            end
            GNT_I0: begin
                bus.ramREN   = 1'b1;
                bus.ramaddr  = bus.iaddr[0];
                bus.iload[0] = bus.ramload;
                bus.iwait[0] = ~access_s;
            end
            GNT_I1: begin
                bus.ramREN   = 1'b1;
                bus.ramaddr  = bus.iaddr[1];
                bus.iload[1] = bus.ramload;
                bus.iwait[1] = ~access_s;
            end
            default: begin
                bus.dwait    = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus randomized traffic,
// all compared cycle by cycle against an owner/round-robin/starvation reference model.
module tb_ram_port_arbiter;
    localparam int         WORD_W     = 32;
    localparam int         STARVE_MAX = 8;
    localparam logic [1:0] R_FREE     = 2'd0;
    localparam logic [1:0] R_BUSY     = 2'd1;
    localparam logic [1:0] R_ACCESS   = 2'd2;
    localparam logic [1:0] R_ERROR    = 2'd3;

    logic CLK = 1'b0;
    logic RST;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: owner -1 = nobody, 0 = data side, 1/2 = icache0/icache1.
    int m_owner;
    int m_rr;
    int m_starve;

    ram_port_arbiter_if #(.WORD_W(WORD_W)) bus ();

    ram_port_arbiter #(.WORD_W(WORD_W), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] ctrl_now();
        return {bus.ramREN, bus.ramWEN, bus.dwait, bus.iwait};
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_rr     = 0;
        m_starve = 0;
    endtask

    // Clock-edge update of the reference model from the inputs held across the edge.
    task automatic model_step();
        bit acc;
        bit d_req;
        int n_i;
        int k;
        acc   = (bus.ramstate == R_ACCESS);
        d_req = bus.dREN || bus.dWEN;
        n_i   = int'(bus.iREN[0]) + int'(bus.iREN[1]);
        if (m_owner == -1) begin
            if (n_i > 0 && m_starve == STARVE_MAX) m_owner = bus.iREN[m_rr] ? 1 + m_rr : 2 - m_rr;
            else if (d_req) m_owner = 0;
            else if (n_i == 2) m_owner = 1 + m_rr;
            else if (n_i == 1) m_owner = bus.iREN[0] ? 1 : 2;
            else m_owner = -1;
        end else if (m_owner == 0) begin
            if (acc) begin
                if (n_i > 0) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
                else m_starve = 0;
                m_owner = (bus.dlock && m_starve < STARVE_MAX) ? 0 : -1;
            end else if (!d_req) begin
                m_owner = -1;
            end
        end else begin
            k = m_owner - 1;
            if (acc) begin
                m_rr     = 1 - k;
                m_starve = 0;
                m_owner  = -1;
            end else if (!bus.iREN[k]) begin
                m_owner = -1;
            end
        end
    endtask

    task automatic compare_outputs();
        logic                   e_ren;
        logic                   e_wen;
        logic                   e_dwait;
        logic [1:0]             e_iwait;
        logic [WORD_W-1:0]      e_addr;
        logic [WORD_W-1:0]      e_store;
        logic [WORD_W-1:0]      e_dload;
        logic [1:0][WORD_W-1:0] e_iload;
        bit                     acc;
        int                     k;
        int                     n_low;
        acc     = (bus.ramstate == R_ACCESS);
        e_ren   = 1'b0;
        e_wen   = 1'b0;
        e_dwait = 1'b1;
        e_iwait = 2'b11;
        e_addr  = '0;
        e_store = '0;
        e_dload = '0;
        e_iload = '0;
        if (m_owner == 0) begin
            e_wen   = bus.dWEN;
            e_ren   = bus.dREN && !bus.dWEN;
            e_addr  = bus.daddr;
            e_store = bus.dstore;
            e_dload = bus.ramload;
            e_dwait = !acc;
        end else if (m_owner > 0) begin
            k          = m_owner - 1;
            e_ren      = 1'b1;
            e_addr     = bus.iaddr[k];
            e_iload[k] = bus.ramload;
            e_iwait[k] = !acc;
        end
        check("ctrl", 64'(ctrl_now()), 64'({e_ren, e_wen, e_dwait, e_iwait}));
        check("ramaddr", 64'(bus.ramaddr), 64'(e_addr));
        check("ramstore", 64'(bus.ramstore), 64'(e_store));
        check("dload", 64'(bus.dload), 64'(e_dload));
        check("iload", 64'(bus.iload), 64'(e_iload));
        n_low = int'(!bus.dwait) + int'(!bus.iwait[0]) + int'(!bus.iwait[1]);
        check("one_wait_low", 64'(n_low <= 1), 64'd1);
    endtask

    // Called just after a falling edge with inputs applied.
    task automatic settle();
        if (RST) model_reset();
        #1;
        compare_outputs();
    endtask

    task automatic advance();
        @(posedge CLK);
        if (RST) model_reset();
        else model_step();
        @(negedge CLK);
    endtask

    task automatic cyc(input logic [1:0] rs);
        bus.ramstate = rs;
        settle();
        advance();
    endtask

    task automatic clear_inputs();
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.dlock    = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.iREN     = 2'b00;
        bus.iaddr[0] = 32'h0000_1000;
        bus.iaddr[1] = 32'h0000_2000;
        bus.ramload  = '0;
        bus.ramstate = R_FREE;
    endtask

    initial begin
        int sel;
        RST = 1'b1;
        clear_inputs();
        model_reset();
        @(negedge CLK);

        // Reset state, then a reset landing in the middle of a data grant.
        settle();
        check("reset_ctrl", 64'(ctrl_now()), 64'h07);
        check("reset_dload", 64'(bus.dload), 64'h0);
        advance();
        RST = 1'b0;
        for (int i = 0; i < 3; i++) cyc(R_FREE);
        bus.dREN = 1'b1;
        bus.daddr = 32'h0000_0040;
        cyc(R_FREE);
        bus.ramstate = R_BUSY;
        settle();
        check("pre_rst_ren", 64'(bus.ramREN), 64'h1);
        advance();
        RST = 1'b1;
        settle();
        check("mid_rst_ctrl", 64'(ctrl_now()), 64'h07);
        advance();
        RST = 1'b0;
        bus.dREN = 1'b0;
        cyc(R_FREE);
        settle();
        check("post_rst_idle", 64'(ctrl_now()), 64'h07);
        advance();

        // Single data read with ACCESS on the third RAM cycle.
        bus.dREN = 1'b1;
        bus.daddr = 32'h0000_0100;
        cyc(R_FREE);
        bus.ramstate = R_BUSY;
        settle();
        check("rd_c1_ctrl", 64'(ctrl_now()), 64'h17);
        check("rd_c1_addr", 64'(bus.ramaddr), 64'h100);
        advance();
        cyc(R_ERROR);
        bus.ramstate = R_ACCESS;
        bus.ramload = 32'hDEAD_BEEF;
        settle();
        check("rd_access_dwait", 64'(bus.dwait), 64'h0);
        check("rd_access_dload", 64'(bus.dload), 64'hDEAD_BEEF);
        advance();
        bus.dREN = 1'b0;
        settle();
        check("rd_back_idle", 64'(ctrl_now()), 64'h07);
        advance();

        // Priority: data first, then icache0, icache1, icache0 as rr toggles.
        bus.dWEN = 1'b1;
        bus.dstore = 32'h1234_5678;
        bus.iREN = 2'b11;
        cyc(R_FREE);
        bus.ramstate = R_ACCESS;
        settle();
        check("pri_data_first", 64'(ctrl_now()), 64'h0B);
        advance();
        bus.dWEN = 1'b0;
        cyc(R_FREE);
        bus.ramstate = R_ACCESS;
        settle();
        check("pri_i0_second", 64'(ctrl_now()), 64'h16);
        advance();
        cyc(R_FREE);
        bus.ramstate = R_ACCESS;
        settle();
        check("pri_i1_third", 64'(ctrl_now()), 64'h15);
        advance();
        cyc(R_FREE);
        bus.ramstate = R_ACCESS;
        settle();
        check("pri_i0_again", 64'(ctrl_now()), 64'h16);
        advance();
        bus.iREN = 2'b00;
        cyc(R_FREE);

        // Lock across two data words while icache0 waits.
        bus.dREN = 1'b1;
        bus.dlock = 1'b1;
        bus.daddr = 32'h0000_0200;
        bus.iREN = 2'b01;
        cyc(R_FREE);
        cyc(R_ACCESS);
        bus.daddr = 32'h0000_0204;
        bus.dlock = 1'b0;
        bus.ramstate = R_ACCESS;
        settle();
        check("lock_word2_addr", 64'(bus.ramaddr), 64'h204);
        check("lock_word2_ctrl", 64'(ctrl_now()), 64'h13);
        advance();
        bus.dREN = 1'b0;
        cyc(R_FREE);
        bus.ramstate = R_ACCESS;
        settle();
        check("lock_then_i0", 64'(ctrl_now()), 64'h16);
        advance();
        bus.iREN = 2'b00;
        cyc(R_FREE);

        // Starvation: lock broken after the eighth data ACCESS, icache1 granted.
        bus.dREN = 1'b1;
        bus.dlock = 1'b1;
        bus.iREN = 2'b10;
        cyc(R_FREE);
        for (int i = 0; i < STARVE_MAX; i++) begin
            bus.daddr = 32'h0000_0300 + 32'(4 * i);
            bus.ramstate = R_ACCESS;
            settle();
            check("starve_data_access", 64'(bus.dwait), 64'h0);
            advance();
        end
        bus.ramstate = R_FREE;
        settle();
        check("starve_lock_broken", 64'(ctrl_now()), 64'h07);
        advance();
        bus.ramstate = R_ACCESS;
        settle();
        check("starve_i1_grant", 64'(ctrl_now()), 64'h15);
        advance();
        bus.iREN = 2'b00;
        cyc(R_FREE);
        bus.dREN = 1'b0;
        bus.dlock = 1'b0;
        cyc(R_FREE);
        cyc(R_FREE);

        // Abort: icache0 drops its request during BUSY.
        bus.iREN = 2'b01;
        cyc(R_FREE);
        bus.ramstate = R_BUSY;
        settle();
        check("abort_busy_ctrl", 64'(ctrl_now()), 64'h17);
        advance();
        bus.iREN = 2'b00;
        settle();
        check("abort_no_pulse", 64'(bus.iwait), 64'h3);
        advance();
        settle();
        check("abort_idle", 64'(ctrl_now()), 64'h07);
        advance();

        // Randomized traffic with requests held for several cycles at a time.
        for (int c = 0; c < 4000; c++) begin
            RST = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 7) == 0) begin
                bus.dREN  = ($urandom_range(0, 1) == 0);
                bus.dWEN  = ($urandom_range(0, 3) == 0);
                bus.dlock = ($urandom_range(0, 2) != 0);
                bus.iREN  = 2'($urandom_range(0, 3));
            end
            bus.daddr    = $urandom();
            bus.dstore   = $urandom();
            bus.iaddr[0] = $urandom();
            bus.iaddr[1] = $urandom();
            bus.ramload  = $urandom();
            sel = $urandom_range(0, 19);
            if (sel < 7) bus.ramstate = R_ACCESS;
            else if (sel < 14) bus.ramstate = R_BUSY;
            else if (sel < 17) bus.ramstate = R_FREE;
            else bus.ramstate = R_ERROR;
            settle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
